delay_scheduler: RTL and testbench

//  Time-multiplexes one shared dual-port sample RAM as CHANNELS independent circular delay lines.

---
 rtl/delay_pkg.sv | 31 +++
 rtl/delay_scheduler_if.sv | 49 ++++
 rtl/delay_ram.sv | 38 +++
 rtl/delay_scheduler.sv | 164 ++++++++++++++++
 tb/tb_delay_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_pkg
// Description : Shared types and helpers for the multi-channel delay
//               scheduler: FSM state encoding and a constant clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_pkg;

  // Scheduler states; CLEAR is the reset state and zero-fills the RAM
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_scheduler_if
// Description : Bundles the sample-path handshake and the shared RAM port of
//               the delay scheduler. The scheduler is the slave side; the
//               surrounding system (voice path, mixer, RAM) is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_scheduler_if
  import delay_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int LEN      = 1024
);

  localparam int AW = clog2(LEN);
  localparam int MW = clog2(CHANNELS * LEN);

  // sample path
  logic                      sample_tick;
  logic [CHANNELS*AW-1:0]    ch_delay;
  logic [CHANNELS*WIDTH-1:0] ch_in;
  logic [CHANNELS*WIDTH-1:0] ch_out;
  logic                      out_valid;
  logic                      busy;
  logic                      overrun;

  // shared sample RAM port
  logic                      mem_we;
  logic [MW-1:0]             mem_waddr;
  logic [WIDTH-1:0]          mem_wdata;
  logic [MW-1:0]             mem_raddr;
  logic [WIDTH-1:0]          mem_rdata;

  modport master (
    output sample_tick, ch_delay, ch_in, mem_rdata,
    input  ch_out, out_valid, busy, overrun,
    input  mem_we, mem_waddr, mem_wdata, mem_raddr
  );

  modport slave (
    input  sample_tick, ch_delay, ch_in, mem_rdata,
    output ch_out, out_valid, busy, overrun,
    output mem_we, mem_waddr, mem_wdata, mem_raddr
  );

endinterface
`default_nettype wire

// File: rtl/delay_ram.sv
`default_nettype none
// ============================================================================
// Module      : delay_ram
// Description : Simple dual-port sample RAM, one write port and one
//               registered read port. A read and write to the same address
//               in the same cycle returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_ram
  import delay_pkg::*;
#(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4096,
  localparam int AW    = clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port plus registered read; non-blocking gives read-before-write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : delay_scheduler
// Description : Time-multiplexes one shared dual-port RAM as CHANNELS
//               circular delay lines with run-time programmable delays.
//               Each sample_tick runs one round: per channel READ the
//               delayed sample, WAIT for the RAM, WRITE the new sample.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_scheduler
  import delay_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int LEN      = 1024
) (
  input wire logic          clk,
  input wire logic          rstn,
  delay_scheduler_if.slave  bus
);

  localparam int AW  = clog2(LEN);
  localparam int CW  = clog2(CHANNELS);
  localparam int CWS = (CW > 0) ? CW : 1;
  localparam int MW  = AW + CW;

  state_e                    state_q, state_d;
  logic [CWS-1:0]            ch_q, ch_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [MW-1:0]             clr_addr_q, clr_addr_d;
  logic                      clr_go_q, clr_go_d;
  logic [CHANNELS*WIDTH-1:0] snap_q, snap_d;
  logic [CHANNELS*WIDTH-1:0] ch_out_q, ch_out_d;
  logic                      overrun_q, overrun_d;

  logic [AW-1:0]             cur_delay;
  logic [AW-1:0]             rd_ptr;
  logic [MW-1:0]             rd_addr;
  logic [MW-1:0]             wr_addr;
  logic                      last_ch;
  logic                      mem_we_c;
  logic [MW-1:0]             mem_waddr_c;
  logic [WIDTH-1:0]          mem_wdata_c;
  logic                      out_valid_c;

  // Delay for the channel being serviced; subtraction wraps modulo LEN
  assign cur_delay = bus.ch_delay[ch_q*AW +: AW];
  assign rd_ptr    = wr_ptr_q - cur_delay;
  assign last_ch   = (ch_q == CWS'(CHANNELS - 1));

  // RAM address is {channel, pointer}; a single channel needs no channel field
  if (CW == 0) begin : g_single_ch
    assign rd_addr = rd_ptr;
    assign wr_addr = wr_ptr_q;
  end else begin : g_multi_ch
    assign rd_addr = {ch_q[CW-1:0], rd_ptr};
    assign wr_addr = {ch_q[CW-1:0], wr_ptr_q};
  end

  // State and datapath registers; reset abandons any round and restarts CLEAR
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_CLEAR;
      ch_q       <= '0;
      wr_ptr_q   <= '0;
      clr_addr_q <= '0;
      clr_go_q   <= 1'b0;
      snap_q     <= '0;
      ch_out_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      wr_ptr_q   <= wr_ptr_d;
      clr_addr_q <= clr_addr_d;
      clr_go_q   <= clr_go_d;
      snap_q     <= snap_d;
      ch_out_q   <= ch_out_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state and output decode for the scheduler FSM
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    wr_ptr_d    = wr_ptr_q;
    clr_addr_d  = clr_addr_q;
    clr_go_d    = 1'b1;
    snap_d      = snap_q;
    ch_out_d    = ch_out_q;
    overrun_d   = overrun_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr;
    mem_wdata_c = '0;
    out_valid_c = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        // clr_go_q keeps the write port quiet while reset is still applied
        if (clr_go_q) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = clr_addr_q;
          if (&clr_addr_q) begin
            clr_addr_d = '0;
            state_d    = ST_IDLE;
          end else begin
            clr_addr_d = clr_addr_q + MW'(1);
          end
        end
      end
      ST_IDLE: begin
        if (bus.sample_tick) begin
          snap_d  = bus.ch_in;
          ch_d    = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ch_out_d[ch_q*WIDTH +: WIDTH] = bus.mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = wr_addr;
        mem_wdata_c = snap_q[ch_q*WIDTH +: WIDTH];
        if (last_ch) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CWS'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        wr_ptr_d    = wr_ptr_q + AW'(1);
        out_valid_c = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // A tick during a round (DONE included) is dropped and flagged; ticks
    // during the CLEAR sweep are dropped silently
    if (bus.sample_tick && (state_q != ST_IDLE) && (state_q != ST_CLEAR)) begin
      overrun_d = 1'b1;
    end
  end

  assign bus.mem_we    = mem_we_c;
  assign bus.mem_waddr = mem_waddr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_raddr = rd_addr;
  assign bus.ch_out    = ch_out_q;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_scheduler
// Description : Directed, scoreboarded bench for delay_scheduler with the
//               sample RAM instantiated beside it (4 channels, LEN 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_scheduler;

  localparam int WIDTH    = 12;
  localparam int CHANNELS = 4;
  localparam int LEN      = 16;
  localparam int AW       = 4;
  localparam int MW       = 6;
  localparam int SW       = CHANNELS * WIDTH;
  localparam int ROUND    = 3 * CHANNELS + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  delay_scheduler_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .LEN(LEN)) bus ();

  delay_scheduler #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .LEN(LEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  delay_ram #(.WIDTH(WIDTH), .DEPTH(CHANNELS * LEN)) ram (
    .clk   (clk),
    .we    (bus.mem_we),
    .waddr (bus.mem_waddr),
    .wdata (bus.mem_wdata),
    .raddr (bus.mem_raddr),
    .rdata (bus.mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  // reference model: every sample written per channel since the last clear
  logic [WIDTH-1:0] hist [CHANNELS][256];
  int               n_ticks = 0;
  int               dly [CHANNELS];
  logic [SW-1:0]    exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_out(input int n);
    logic [SW-1:0] v;
    int d;
    v = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      d = (dly[k] == 0) ? LEN : dly[k];
      if (n - d >= 0) v[k*WIDTH +: WIDTH] = hist[k][n - d];
    end
    return v;
  endfunction

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    bus.ch_delay = {AW'(d3), AW'(d2), AW'(d1), AW'(d0)};
  endtask

  // Record a tick in the model; returns with the tick line driven high
  task automatic start_tick(input logic [SW-1:0] samples);
    for (int k = 0; k < CHANNELS; k++) hist[k][n_ticks] = samples[k*WIDTH +: WIDTH];
    exp_q.push_back(model_out(n_ticks));
    n_ticks++;
    bus.ch_in       = samples;
    bus.sample_tick = 1'b1;
  endtask

  // One full round from IDLE: latency, output data and pulse width
  task automatic do_tick(input logic [SW-1:0] samples);
    int cnt;
    start_tick(samples);
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.ch_in       = SW'({$urandom(), $urandom()});
    cnt = 1;
    while (bus.out_valid !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("out_valid_seen", 64'(bus.out_valid), 64'd1);
    check("tick_latency", 64'(cnt), 64'(ROUND));
    if (bus.out_valid === 1'b1) check("ch_out", 64'(bus.ch_out), 64'(exp_q.pop_front()));
    @(negedge clk);
    check("out_valid_width", 64'(bus.out_valid), 64'd0);
    check("idle_after_round", 64'(bus.busy), 64'd0);
  endtask

  // Called on the negedge where rstn was just released
  task automatic sweep_check(input string tag);
    int we_cnt, bad, busy_cnt, ov_cnt;
    we_cnt = 0; bad = 0; busy_cnt = 0; ov_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      busy_cnt++;
      if (bus.mem_we === 1'b1) begin
        if (bus.mem_waddr !== we_cnt[MW-1:0] || bus.mem_wdata !== '0) bad++;
        we_cnt++;
      end
      if (bus.out_valid === 1'b1) ov_cnt++;
      bus.sample_tick = (i == 10);
    end
    bus.sample_tick = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(CHANNELS * LEN));
    check({tag, "_writes"}, 64'(we_cnt), 64'(CHANNELS * LEN));
    check({tag, "_bad_writes"}, 64'(bad), 64'd0);
    check({tag, "_out_valid"}, 64'(ov_cnt), 64'd0);
    check({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
    check({tag, "_ch_out"}, 64'(bus.ch_out), 64'd0);
    n_ticks = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2_exp [5];
    int ov_cnt;
    int exp_addr;
    logic [SW-1:0] s;

    t2_exp = '{0, 0, 0, 1, 2};
    bus.sample_tick = 1'b0;
    bus.ch_in       = '0;
    set_delays(0, 0, 0, 0);

    // 1. reset state and clear sweep, with a dropped tick mid-sweep
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd1);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_ch_out", 64'(bus.ch_out), 64'd0);
    rstn = 1'b1;
    sweep_check("clear1");

    // 2. ch0 delay 3, inputs 1..5
    set_delays(3, 1, 2, 4);
    for (int i = 0; i < 5; i++) begin
      s = SW'({$urandom(), $urandom()});
      s[WIDTH-1:0] = WIDTH'(i + 1);
      do_tick(s);
      check("t2_ch0", 64'(bus.ch_out[WIDTH-1:0]), 64'(t2_exp[i]));
    end

    // 3. mixed delays including d=0 (LEN), ramp input tagged by channel
    set_delays(1, 2, 5, 0);
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < CHANNELS; k++) s[k*WIDTH +: WIDTH] = WIDTH'((k << 8) | n_ticks);
      do_tick(s);
    end

    // 4. long run at delay 15 across several pointer wraps
    set_delays(15, 15, 15, 15);
    for (int i = 0; i < 40; i++) do_tick(SW'({$urandom(), $urandom()}));

    // 5. second tick 5 cycles after the first
    check("pre_overrun", 64'(bus.overrun), 64'd0);
    set_delays(2, 3, 1, 7);
    start_tick(SW'({$urandom(), $urandom()}));
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    check("overrun_set", 64'(bus.overrun), 64'd1);
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) begin
        ov_cnt++;
        if (exp_q.size() > 0) check("overrun_ch_out", 64'(bus.ch_out), 64'(exp_q.pop_front()));
      end
      @(negedge clk);
    end
    check("overrun_valid_count", 64'(ov_cnt), 64'd1);
    check("overrun_sticky", 64'(bus.overrun), 64'd1);

    // 6. reset during WRITE of ch2
    s = SW'({$urandom(), $urandom()});
    bus.ch_in = s;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (8) @(negedge clk);
    exp_addr = 2 * LEN + (n_ticks % LEN);
    check("write_ch2_we", 64'(bus.mem_we), 64'd1);
    check("write_ch2_addr", 64'(bus.mem_waddr), 64'(exp_addr));
    check("write_ch2_data", 64'(bus.mem_wdata), 64'(s[2*WIDTH +: WIDTH]));
    rstn = 1'b0;
    @(negedge clk);
    check("abort_mem_we", 64'(bus.mem_we), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd1);
    check("abort_ch_out", 64'(bus.ch_out), 64'd0);
    check("abort_overrun", 64'(bus.overrun), 64'd0);
    @(negedge clk);
    check("abort_mem_we_hold", 64'(bus.mem_we), 64'd0);
    rstn = 1'b1;
    sweep_check("clear2");
    set_delays(1, 2, 3, 0);
    do_tick(SW'({$urandom(), $urandom()}));
    do_tick(SW'({$urandom(), $urandom()}));

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
